seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational ALU, sitting between the accumulator/MBR datapath and the control sequencer.
- Keeps the 4-bit opcode map and registers its result.
- Adds status flags and a start/done handshake.
- Multiply and divide are multi-cycle (shift-add multiply, restoring divide) instead of a single combinational operator.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
opcode  input  4  operation select (map below)
operand1  input  WIDTH  first operand, captured on accept
operand2  input  WIDTH  second operand, captured on accept
ready  output  1  1 when idle and able to accept start
busy  output  1  1 while a multi-cycle op is iterating
done  output  1  one-cycle pulse: result/flags updated
result  output  WIDTH  registered result, held until the next completion
flag_zero  output  1  result==0
flag_carry  output  1  carry/borrow/shift-out/overflow, per op
flag_div0  output  1  last divide had operand2==0

Behaviour:
- Reset:
  - reset=0 immediately forces state IDLE, result=0, all flags=0, done=0, busy=0, ready=1.
  - This applies mid-operation too; the operation in flight is discarded.
- States:
  - IDLE: ready=1.
  - MUL and DIV: busy=1, ready=0.
  - DONE: done=1, ready=0. DONE lasts exactly one cycle, then returns to IDLE.
- Accept:
  - start=1 with ready=1 at edge k captures opcode and operands.
  - start while ready=0 is ignored; no queueing.
- Opcode map:
  - 0 add, 1 sub, 2 mul, 3 div
  - 4 shl1, 5 shr1, 6 rotl1, 7 rotr1
  - 8 and, 9 or, A xor, B nor, C nand, D xnor
  - E greater-than (unsigned, result 1/0), F equal (result 1/0)
- Single-cycle ops (all except 2, and 3 with nonzero divisor):
  - Result and flags are written at edge k.
  - State goes to DONE, so done is high in the cycle after edge k.
- Multiply (op 2):
  - Unsigned shift-add, one operand2 bit per cycle, WIDTH iterations at edges k+1..k+WIDTH.
  - State enters DONE at edge k+WIDTH.
  - result = low WIDTH bits of the 2*WIDTH product.
  - flag_carry = 1 if any high product bit is nonzero.
- Divide (op 3), operand2!=0:
  - Unsigned restoring divide, WIDTH iterations, same timing as multiply.
  - result = quotient; remainder is discarded; flag_carry=0.
- Divide (op 3), operand2==0:
  - No iteration; single-cycle latency.
  - result = all ones, flag_div0=1, flag_carry=0.
- flag_div0 is cleared by any other completed op.
- flag_carry by op:
  - add: carry out of bit WIDTH-1.
  - sub: borrow (operand1<operand2).
  - shl1: operand1[WIDTH-1].
  - shr1: operand1[0].
  - mul: overflow, as above.
  - All other ops: 0.
- flag_zero is computed from the new result at every completion.
- Arithmetic:
  - All ops are unsigned, modulo 2^WIDTH.
  - Shifts and rotates use operand1 only; operand2 is ignored.
- Operand inputs may change after accept without affecting the operation in progress.
- Throughput:
  - A new start can be accepted in IDLE only, i.e. one cycle after DONE.
  - Back-to-back single-cycle ops therefore complete every 2 cycles.

Test Plan:
- Add overflow: add 0xFFFF+0x0001 -> after 1 edge done=1 for exactly one cycle, result=0x0000, flag_zero=1, flag_carry=1; ready returns to 1 the cycle after.
- Multiply:
  - 0x0123*0x0010 -> busy=1 for 16 cycles, done at edge k+16, result=0x1230, flag_carry=0.
  - 0x1000*0x0010 -> result=0x0000, flag_zero=1, flag_carry=1.
- Divide:
  - 100/7 -> done at edge k+16, result=14 (0x000E), flag_div0=0.
  - 5/0 -> done after 1 edge, result=0xFFFF, flag_div0=1.
  - A following 1+1 -> result=2, flag_div0=0.
- Busy rejection: start mul 3*5, then assert start with add 1+1 at cycle 4 -> ignored, ready=0; the single done pulse carries result=15.
- Reset mid-op: start div 0xFFFF/3, pull reset low at cycle 8 -> result=0, flags=0, busy=0, done=0, ready=1 immediately. After release, sub 2-3 -> result=0xFFFF, flag_carry=1.
- Shift/compare corners:
  - rotl1 0x8001 -> 0x0003.
  - rotr1 0x0001 -> 0x8000.
  - shr1 0x0001 -> 0x0000 with flag_carry=1, flag_zero=1.
  - gt 3>2 -> 1.
  - eq 0x00AA==0x00AB -> 0 with flag_zero=1.

Source files
------------

// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle.
// The master side issues start/opcode/operands; the ALU returns status and result.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_div0;

  modport master (
    output start,
    output opcode,
    output operand1,
    output operand2,
    input  ready,
    input  busy,
    input  done,
    input  result,
    input  flag_zero,
    input  flag_carry,
    input  flag_div0
  );

  modport slave (
    input  start,
    input  opcode,
    input  operand1,
    input  operand2,
    output ready,
    output busy,
    output done,
    output result,
    output flag_zero,
    output flag_carry,
    output flag_div0
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: registered result and flags with a start/done handshake.
// Multiply is shift-add, divide is restoring; both take WIDTH iterations.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;

  logic [WIDTH-1:0]   result;
  logic               flag_zero;
  logic               flag_carry;
  logic               flag_div0;
  logic               ready;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_n;
  logic               carry_n;
  logic               div0_n;
  logic               iter_op;

  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;

  assign op1 = bus.operand1;
  assign op2 = bus.operand2;

  assign bus.result     = result;
  assign bus.flag_zero  = flag_zero;
  assign bus.flag_carry = flag_carry;
  assign bus.flag_div0  = flag_div0;
  assign bus.ready      = ready;
  assign bus.busy       = busy;
  assign bus.done       = done;

  // Only mul and a non-zero divide go through the iterating states.
  assign iter_op = (bus.opcode == OP_MUL) ||
                   (bus.opcode == OP_DIV &&
                    op2 != '0);

  always_comb begin
    sum     = {1'b0, op1} + {1'b0, op2};
    res_n   = '0;
    carry_n = 1'b0;
    div0_n  = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        res_n   = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      OP_SUB: begin
        res_n   = op1 - op2;
        carry_n = op1 < op2;
      end
      OP_MUL: res_n = '0;
      OP_DIV: begin
        res_n  = '1;
        div0_n = 1'b1;
      end
      OP_SHL: begin
        res_n   = {op1[WIDTH-2:0], 1'b0};
        carry_n = op1[WIDTH-1];
      end
      OP_SHR: begin
        res_n   = {1'b0, op1[WIDTH-1:1]};
        carry_n = op1[0];
      end
      OP_ROL:  res_n = {op1[WIDTH-2:0], op1[WIDTH-1]};
      OP_ROR:  res_n = {op1[0], op1[WIDTH-1:1]};
      OP_AND:  res_n = op1 & op2;
      OP_OR:   res_n = op1 | op2;
      OP_XOR:  res_n = op1 ^ op2;
      OP_NOR:  res_n = ~(op1 | op2);
      OP_NAND: res_n = ~(op1 & op2);
      OP_XNOR: res_n = ~(op1 ^ op2);
      OP_GT:   res_n = WIDTH'(op1 > op2);
      OP_EQ:   res_n = WIDTH'(op1 == op2);
      default: res_n = '0;
    endcase
  end

  always_comb begin
    prod_n = prod + (mplr[0] ? mcand : '0);
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
    // No borrow out of the trial subtract means the divisor fits.
    qbit   = ~trial[WIDTH];
    rem_n  = qbit ? trial[WIDTH-1:0]
                  : rem_sh[WIDTH-1:0];
    quo_n  = {quo[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      prod       <= '0;
      mcand      <= '0;
      mplr       <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_div0  <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start && iter_op) begin
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (bus.opcode == OP_MUL) begin
              prod  <= '0;
              mcand <= {{WIDTH{1'b0}}, op1};
              mplr  <= op2;
              state <= MUL;
            end else begin
              rem   <= '0;
              quo   <= op1;
              dvs   <= op2;
              state <= DIV;
            end
          end else if (bus.start) begin
            result     <= res_n;
            flag_zero  <= res_n == '0;
            flag_carry <= carry_n;
            flag_div0  <= div0_n;
            ready      <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        MUL: begin
          prod  <= prod_n;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result     <= prod_n[WIDTH-1:0];
            flag_zero  <= prod_n[WIDTH-1:0] == '0;
            flag_carry <= |prod_n[2*WIDTH-1:WIDTH];
            flag_div0  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result     <= quo_n;
            flag_zero  <= quo_n == '0;
            flag_carry <= 1'b0;
            flag_div0  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
